// File: rtl/pe_mac_seq.sv
// pe_mac_seq: sequenced MAC processing element. Holds kernel and neuron stores and runs
// a full LEN-term signed dot product plus incoming partial sum per start command.
// Pipeline: issue (address reg) -> store read -> product reg -> accumulate.
module pe_mac_seq #(
   parameter int unsigned W     = 16,
   parameter int unsigned A     = 7,
   parameter int unsigned ACC_W = 40,
   parameter int unsigned FRAC  = 0,
   parameter bit          SAT   = 1'b1
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                k_we,
   input  logic [A-1:0]        k_waddr,
   input  logic [W-1:0]        k_wdata,
   input  logic                n_we,
   input  logic [A-1:0]        n_waddr,
   input  logic [W-1:0]        n_wdata,
   input  logic                start,
   input  logic [A:0]          len,
   input  logic [A-1:0]        k_base,
   input  logic [A-1:0]        n_base,
   input  logic [A-1:0]        n_stride,
   input  logic signed [W-1:0] psum_in,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        out_data,
   output logic                out_sat
);

   localparam int unsigned Depth = 2 ** A;
   localparam logic signed [ACC_W-1:0] MaxV = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MinV = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic signed [W-1:0]     kmem [Depth];
   logic signed [W-1:0]     nmem [Depth];
   logic signed [W-1:0]     kr_q, nr_q;
   logic signed [2*W-1:0]   pr_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] shifted;
   logic [A:0]              len_q, cnt_q;
   logic [A+1:0]            cnt_nx;
   logic [A-1:0]            ka_q, na_q, stride_q;
   logic                    iv_q, rv_q, pv_q;
   logic                    out_valid_q, out_sat_q;
   logic [W-1:0]            out_data_q, res_data;
   logic                    over, under;
   logic                    accept, issue_run, res_load, hs;

   // State register
   always_ff @(posedge CLK) begin
      if (!RSTn) state_q <= StIdle;
      else       state_q <= state_d;
   end

   assign cnt_nx = {1'b0, cnt_q} + 1'b1;

   // Next-state decode; DRAIN ends when the last product is being accumulated this edge
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = (len == '0) ? StDone : StRun;
         StRun:   if (cnt_nx >= {1'b0, len_q}) state_d = StDrain;
         StDrain: if (!iv_q && !rv_q) state_d = StDone;
         StDone:  if (hs) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Control strobes derived from state
   always_comb begin
      accept    = (state_q == StIdle) && start;
      issue_run = (state_q == StRun) && (cnt_q < len_q);
      res_load  = (state_q == StDone) && !out_valid_q;
      hs        = out_valid_q && out_ready;
   end

   // Store writes, accepted in any state; contents are not reset
   always_ff @(posedge CLK) begin
      if (k_we) kmem[k_waddr] <= k_wdata;
      if (n_we) nmem[n_waddr] <= n_wdata;
   end

   // Synchronous read of the issued addresses; same-edge writes are not visible (read-first)
   always_ff @(posedge CLK) begin
      if (iv_q) begin
         kr_q <= kmem[ka_q];
         nr_q <= nmem[na_q];
      end
   end

   // Address generation, pipeline valids, product and accumulator
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         len_q    <= '0;
         cnt_q    <= '0;
         ka_q     <= '0;
         na_q     <= '0;
         stride_q <= '0;
         iv_q     <= 1'b0;
         rv_q     <= 1'b0;
         pv_q     <= 1'b0;
         pr_q     <= '0;
         acc_q    <= '0;
      end else begin
         rv_q <= iv_q;
         pv_q <= rv_q;
         if (rv_q) pr_q <= kr_q * nr_q;
         if (accept) begin
            len_q    <= len;
            cnt_q    <= {{A{1'b0}}, 1'b1};
            ka_q     <= k_base;
            na_q     <= n_base;
            stride_q <= n_stride;
            iv_q     <= (len != '0);
         end else if (issue_run) begin
            cnt_q <= cnt_q + 1'b1;
            ka_q  <= ka_q + 1'b1;
            na_q  <= na_q + stride_q;
            iv_q  <= 1'b1;
         end else begin
            iv_q <= 1'b0;
         end
         if (accept)    acc_q <= ACC_W'(psum_in);
         else if (pv_q) acc_q <= acc_q + ACC_W'(pr_q);
      end
   end

   // Output scaling and range check of the final accumulator
   always_comb begin
      shifted = acc_q >>> FRAC;
      over    = shifted > MaxV;
      under   = shifted < MinV;
      if (SAT && over)       res_data = {1'b0, {(W-1){1'b1}}};
      else if (SAT && under) res_data = {1'b1, {(W-1){1'b0}}};
      else                   res_data = shifted[W-1:0];
   end

   // Result register, held until the downstream handshake
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (res_load) begin
         out_valid_q <= 1'b1;
         out_data_q  <= res_data;
         out_sat_q   <= over | under;
      end else if (hs) begin
         out_valid_q <= 1'b0;
      end
   end

   assign busy      = (state_q != StIdle);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule
